cover_toggle_collector: RTL

COVER_TOGGLE_COLLECTOR -- requirements
Module: cover_toggle_collector

---
 rtl/cover_toggle_collector_pkg.sv | 18 +
 rtl/cover_toggle_collector_popcount.sv | 18 +
 rtl/cover_toggle_collector.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/cover_toggle_collector_pkg.sv
// Shared sizing constants and controller state encoding for the toggle
// coverage collector.
package cover_pkg;

  localparam int unsigned COVER_TOTAL = 9715;
  localparam int unsigned WIDTH       = 36;
  localparam int unsigned DEPTH       = (COVER_TOTAL + WIDTH - 1) / WIDTH;
  localparam int unsigned AW          = $clog2(DEPTH);
  localparam int unsigned CW          = $clog2(COVER_TOTAL + 1);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    CLEAR,
    DUMP
  } state_t;

endpackage

// File: rtl/cover_toggle_collector_popcount.sv
// Combinational population count of one hit word.
module cover_popcount #(
  parameter int unsigned WIDTH = cover_pkg::WIDTH,
  parameter int unsigned CW    = cover_pkg::CW
) (
  input  logic [WIDTH-1:0] bits,
  output logic [CW-1:0]    count
);

  // Sum the set bits of the input word.
  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/cover_toggle_collector.sv
// Toggle coverage collector: accumulates hit words into a bitmap, counts
// distinct covered points, and supports clear and streamed readout.
module cover_toggle_collector
  import cover_pkg::state_t, cover_pkg::IDLE, cover_pkg::DRAIN,
         cover_pkg::CLEAR, cover_pkg::DUMP;
#(
  parameter  int unsigned COVER_TOTAL = cover_pkg::COVER_TOTAL,
  parameter  int unsigned WIDTH       = cover_pkg::WIDTH,
  localparam int unsigned DEPTH       = (COVER_TOTAL + WIDTH - 1) / WIDTH,
  localparam int unsigned AW          = $clog2(DEPTH),
  localparam int unsigned CW          = $clog2(COVER_TOTAL + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             hit_valid,
  input  logic [AW-1:0]    hit_word,
  input  logic [WIDTH-1:0] hit_bits,
  output logic             hit_ready,
  input  logic             clear_req,
  input  logic             dump_req,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [AW-1:0]    dump_word,
  output logic [WIDTH-1:0] dump_data,
  output logic             dump_last,
  output logic [CW-1:0]    covered_count,
  output logic             new_hit,
  output logic             err_oob,
  output logic             busy
);

  localparam logic [AW:0]      DEPTH_X   = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0]    LAST      = AW'(DEPTH - 1);
  localparam int unsigned      TAIL      = COVER_TOTAL - (DEPTH - 1) * WIDTH;
  localparam logic [WIDTH-1:0] TAIL_MASK = {WIDTH{1'b1}} >> (WIDTH - TAIL);

  state_t           state;
  logic             dump_sel;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             p_valid;
  logic [AW-1:0]    p_word;
  logic [WIDTH-1:0] p_new;
  logic [CW-1:0]    p_cnt;

  logic             hit_fire;
  logic             hit_oob;
  logic [WIDTH-1:0] hit_mask;
  logic [WIDTH-1:0] old_bits;
  logic [WIDTH-1:0] new_bits;
  logic [CW-1:0]    new_cnt;
  logic [WIDTH-1:0] dump_next;

  assign dump_word = addr;
  assign busy      = (state != IDLE);

  // Acceptance and new-bit extraction; the pending commit is merged into the
  // stored word so a same-word follow-up sees bits not yet written back.
  always_comb begin
    hit_ready = (state == IDLE) && !clear_req && !dump_req;
    hit_fire  = hit_valid && hit_ready;
    hit_oob   = {1'b0, hit_word} >= DEPTH_X;
    hit_mask  = (hit_word == LAST) ? TAIL_MASK : '1;
    old_bits  = hit_oob ? '0 : mem[hit_word];
    if (p_valid && (p_word == hit_word)) begin
      old_bits = old_bits | p_new;
    end
    new_bits  = hit_bits & hit_mask & ~old_bits;
    dump_next = (addr == LAST) ? '0 : mem[addr + AW'(1)];
  end

  cover_popcount #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_popcount (
    .bits  (new_bits),
    .count (new_cnt)
  );

  // Bitmap storage: the CLEAR sweep zeroes words, otherwise commit new bits.
  always_ff @(posedge clock) begin
    if (state == CLEAR) begin
      mem[addr] <= '0;
    end else if (p_valid && reset) begin
      mem[p_word] <= mem[p_word] | p_new;
    end
  end

  // Controller, commit pipeline and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= CLEAR;
      dump_sel      <= 1'b0;
      addr          <= '0;
      dump_valid    <= 1'b0;
      dump_last     <= 1'b0;
      dump_data     <= '0;
      new_hit       <= 1'b0;
      err_oob       <= 1'b0;
      covered_count <= '0;
      p_valid       <= 1'b0;
    end else begin
      new_hit <= 1'b0;
      p_valid <= 1'b0;
      if (p_valid) begin
        covered_count <= covered_count + p_cnt;
        new_hit       <= (p_cnt != '0);
      end
      if (hit_fire) begin
        if (hit_oob) begin
          err_oob <= 1'b1;
        end else begin
          p_valid <= 1'b1;
          p_word  <= hit_word;
          p_new   <= new_bits;
          p_cnt   <= new_cnt;
        end
      end

      case (state)
        IDLE: begin
          if (dump_req) begin
            state    <= DRAIN;
            dump_sel <= 1'b1;
          end else if (clear_req) begin
            state    <= DRAIN;
            dump_sel <= 1'b0;
          end
        end
        DRAIN: begin
          addr <= '0;
          if (dump_sel) begin
            state      <= DUMP;
            dump_valid <= 1'b1;
            dump_data  <= mem[0];
            dump_last  <= (DEPTH == 1);
          end else begin
            state <= CLEAR;
          end
        end
        CLEAR: begin
          if (addr == '0) begin
            covered_count <= '0;
            err_oob       <= 1'b0;
          end
          if (addr == LAST) begin
            state <= IDLE;
            addr  <= '0;
          end else begin
            addr <= addr + AW'(1);
          end
        end
        DUMP: begin
          if (dump_ready) begin
            if (dump_last) begin
              state      <= IDLE;
              dump_valid <= 1'b0;
              dump_last  <= 1'b0;
              addr       <= '0;
            end else begin
              addr      <= addr + AW'(1);
              dump_data <= dump_next;
              dump_last <= ((addr + AW'(1)) == LAST);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
